// File: rtl/reg_write_decoder.sv
// rtl/reg_write_decoder.sv - round-robin register-file write-port arbiter with registered one-hot decode
// Optional ZERO_REG_SUPPRESS_EN: grants to address 2^ADDR_W-1 are consumed but produce no write.
module reg_write_decoder #(
  parameter  int ADDR_W   = 5,
  parameter  int CHANNELS = 2,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NREG     = 1 << ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [CHANNELS-1:0]          req_valid,
  input  logic [CHANNELS*ADDR_W-1:0]   req_addr,
  output logic [CHANNELS-1:0]          req_ready,
  output logic [NREG-1:0]              wr_en,
  output logic                         wr_valid,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [CH_W-1:0]              wr_chan,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0]     wr_en_q, wr_en_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CH_W-1:0]     wr_chan_q, wr_chan_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [CHANNELS-1:0] grant_vec;
  logic                grant_any;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W:0]       cand;
  logic [ADDR_W-1:0]   grant_addr;
  logic                zero_hit;
  logic [CH_W:0]       stall_inc;
  logic [CNT_W:0]      stall_sum;

  // Search starts at rr_ptr and wraps; reset gating keeps ready low while held in reset.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(CHANNELS)) begin
        cand = cand - (CH_W+1)'(CHANNELS);
      end
      if (!grant_any && en && reset && req_valid[cand[CH_W-1:0]]) begin
        grant_any                  = 1'b1;
        grant_idx                  = cand[CH_W-1:0];
        grant_vec[cand[CH_W-1:0]]  = 1'b1;
      end
    end
  end

  assign req_ready  = grant_vec;
  assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];

`ifdef ZERO_REG_SUPPRESS_EN
  assign zero_hit = (grant_addr == {ADDR_W{1'b1}});
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = '0;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_chan_d   = wr_chan_q;
    if (grant_any) begin
      rr_ptr_d   = (grant_idx == CH_W'(CHANNELS-1)) ? '0 : grant_idx + CH_W'(1);
      wr_addr_d  = grant_addr;
      wr_chan_d  = grant_idx;
      wr_valid_d = !zero_hit;
      wr_en_d    = zero_hit ? '0 : (NREG'(1) << grant_addr);
    end
  end

  // Only need to detect overflow past the top bit: one cycle adds at most CHANNELS.
  always_comb begin
    stall_inc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      stall_inc = stall_inc + (CH_W+1)'(req_valid[c] & ~grant_vec[c]);
    end
    stall_sum   = {1'b0, stall_cnt_q} + (CNT_W+1)'(stall_inc);
    stall_cnt_d = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      wr_en_q     <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_chan_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_chan_q   <= wr_chan_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_chan   = wr_chan_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_write_decoder.sv
// tb/tb_reg_write_decoder.sv - self-checking bench for reg_write_decoder
// Directed table, hand sequences and constrained-random traffic against a reference model.
module tb_reg_write_decoder;

  localparam int CH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_addr = '0;
  logic [1:0]  req_ready;
  logic [31:0] wr_en;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic        wr_chan;
  logic [15:0] stall_cnt;

  logic        s_reset = 1'b1;
  logic        s_en = 1'b0;
  logic [2:0]  s_valid = 3'b111;
  logic [14:0] s_addr = {5'd2, 5'd1, 5'd0};
  logic [2:0]  s_ready;
  logic [31:0] s_wr_en;
  logic        s_wr_valid;
  logic [4:0]  s_wr_addr;
  logic [1:0]  s_wr_chan;
  logic [3:0]  s_stall;

  reg_write_decoder #(.ADDR_W(5), .CHANNELS(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .wr_en(wr_en), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_chan(wr_chan), .stall_cnt(stall_cnt)
  );

  reg_write_decoder #(.ADDR_W(5), .CHANNELS(3), .CNT_W(4)) u_sat (
    .clk(clk), .reset(s_reset), .en(s_en), .req_valid(s_valid), .req_addr(s_addr),
    .req_ready(s_ready), .wr_en(s_wr_en), .wr_valid(s_wr_valid), .wr_addr(s_wr_addr),
    .wr_chan(s_wr_chan), .stall_cnt(s_stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          m_ptr, m_stall, m_addr, m_chan;
  logic [31:0] m_wr_en;
  logic        m_valid;

  typedef struct {
    logic        en;
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  rdy;
    logic [31:0] wen;
    logic        wv;
    logic [4:0]  wa;
    logic        wc;
    int          st;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [1:0] v, input logic e);
    if (!e) return -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_stall = 0; m_addr = 0; m_chan = 0; m_wr_en = '0; m_valid = 1'b0;
  endtask

  // Entered and left at posedge+1; ready sampled mid-cycle, registered outputs after the edge.
  task automatic cycle(input logic e, input logic [1:0] v, input logic [4:0] a0,
                       input logic [4:0] a1, output logic [1:0] rdy_seen);
    int g;
    int stalled;
    logic [4:0] ga;
    logic zero;
    en = e; req_valid = v; req_addr = {a1, a0};
    g = model_grant(v, e);
    #3;
    rdy_seen = req_ready;
    chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk); #1;
    stalled = int'(v[0]) + int'(v[1]) - ((g >= 0) ? 1 : 0);
    m_stall = (m_stall + stalled > 65535) ? 65535 : m_stall + stalled;
    if (g >= 0) begin
      ga = (g == 0) ? a0 : a1;
      m_ptr = (g + 1) % CH;
      m_addr = ga;
      m_chan = g;
      zero = 1'b0;
`ifdef ZERO_REG_SUPPRESS_EN
      zero = (ga == 5'd31);
`endif
      m_valid = !zero;
      m_wr_en = zero ? 32'd0 : (32'd1 << ga);
    end else begin
      m_valid = 1'b0;
      m_wr_en = '0;
    end
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_valid", wr_valid, m_valid);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_chan", wr_chan, m_chan);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_chan"}, wr_chan, 0);
    chk({tag, "_stall"}, stall_cnt, 0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    en = 1'b1; req_valid = 2'b11;
    #1;
    check_cleared(tag);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    logic [1:0] pv;
    logic [4:0] pa0, pa1;
    int exp_s;

    tbl[0] = '{1'b1, 2'b11, 5'd3, 5'd7, 2'b01, 32'h8,  1'b1, 5'd3, 1'b0, 1};
    tbl[1] = '{1'b1, 2'b11, 5'd3, 5'd7, 2'b10, 32'h80, 1'b1, 5'd7, 1'b1, 2};
    tbl[2] = '{1'b1, 2'b11, 5'd3, 5'd7, 2'b01, 32'h8,  1'b1, 5'd3, 1'b0, 3};
    tbl[3] = '{1'b1, 2'b11, 5'd3, 5'd7, 2'b10, 32'h80, 1'b1, 5'd7, 1'b1, 4};
    tbl[4] = '{1'b0, 2'b11, 5'd3, 5'd7, 2'b00, 32'h0,  1'b0, 5'd7, 1'b1, 6};
    tbl[5] = '{1'b0, 2'b11, 5'd3, 5'd7, 2'b00, 32'h0,  1'b0, 5'd7, 1'b1, 8};
    tbl[6] = '{1'b0, 2'b11, 5'd3, 5'd7, 2'b00, 32'h0,  1'b0, 5'd7, 1'b1, 10};
    tbl[7] = '{1'b1, 2'b01, 5'd5, 5'd9, 2'b01, 32'h20, 1'b1, 5'd5, 1'b0, 10};
    tbl[8] = '{1'b1, 2'b10, 5'd5, 5'd0, 2'b10, 32'h1,  1'b1, 5'd0, 1'b1, 10};
    tbl[9] = '{1'b1, 2'b00, 5'd5, 5'd0, 2'b00, 32'h0,  1'b0, 5'd0, 1'b1, 10};

    model_reset();
    #2;
    reset = 1'b0;
    s_reset = 1'b0;
    #1;
    en = 1'b1; req_valid = 2'b11;
    #1;
    check_cleared("reset");
    chk("sat_reset_stall", s_stall, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int a = 0; a <= 30; a++) begin
      cycle(1'b1, 2'b01, 5'(a), 5'd0, r);
      chk("sweep_wr_en", wr_en, 32'd1 << a);
    end

    apply_reset("rst2");
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].a0, tbl[i].a1, r);
      chk($sformatf("tbl%0d_ready", i), r, tbl[i].rdy);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].wen);
      chk($sformatf("tbl%0d_wr_valid", i), wr_valid, tbl[i].wv);
      chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("tbl%0d_wr_chan", i), wr_chan, tbl[i].wc);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].st);
    end

    cycle(1'b1, 2'b01, 5'd31, 5'd0, r);
    chk("zero_ready", r, 2'b01);
    chk("zero_wr_addr", wr_addr, 31);
`ifdef ZERO_REG_SUPPRESS_EN
    chk("zero_wr_en", wr_en, 0);
    chk("zero_wr_valid", wr_valid, 0);
`else
    chk("zero_wr_en", wr_en, 32'h8000_0000);
    chk("zero_wr_valid", wr_valid, 1);
`endif

    pv = '0; pa0 = '0; pa1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv[0] && $urandom_range(0, 2) != 0) begin pv[0] = 1'b1; pa0 = 5'($urandom); end
      if (!pv[1] && $urandom_range(0, 2) != 0) begin pv[1] = 1'b1; pa1 = 5'($urandom); end
      cycle($urandom_range(0, 7) != 0, pv, pa0, pa1, r);
      pv = pv & ~r;
    end

    cycle(1'b1, 2'b01, 5'd9, 5'd0, r);
    chk("midrst_pre_valid", wr_valid, 1);
    apply_reset("midrst");
    cycle(1'b1, 2'b11, 5'd4, 5'd6, r);
    chk("midrst_first_grant", r, 2'b01);
    chk("midrst_first_chan", wr_chan, 0);

    s_reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_s = (3 * k > 15) ? 15 : 3 * k;
      chk("sat_stall", s_stall, exp_s);
      chk("sat_ready", s_ready, 0);
    end
    s_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("sat_hold", s_stall, 15);
      chk("sat_wr_valid", s_wr_valid, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_decoder.md
# reg_write_decoder

Parametrised, registered write-port decoder for the pipelined processor's register file. It accepts write requests from CHANNELS independent producers (e.g. ALU writeback, load writeback) and arbitrates them round-robin, one per cycle. The granted address is decoded to a 2^ADDR_W one-hot write-enable vector, registered for one cycle, and presented to the register file. It also keeps a saturating count of stalled request-cycles for performance monitoring.

## Interface
- ADDR_W, default 5: register address width; the one-hot output is 2^ADDR_W bits.
- CHANNELS, default 2: number of requesting channels, 1..8.
- CNT_W, default 16: stall counter width.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  global enable; when 0, no grants are issued.
- req_valid  input  CHANNELS  per-channel request valid.
- req_addr  input  CHANNELS*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  output  CHANNELS  combinational grant; a request is consumed when valid and ready are both 1 at a clock edge.
- wr_en  output  2^ADDR_W  registered one-hot write enable.
- wr_valid  output  1  registered; 1 when wr_en carries a write.
- wr_addr  output  ADDR_W  registered address of the granted write.
- wr_chan  output  $clog2(CHANNELS) (minimum 1)  registered index of the granted channel.
- stall_cnt  output  CNT_W  saturating count of stalled request-cycles.

## Operation
- Round-robin pointer rr_ptr names the channel with the highest priority this cycle. The search runs rr_ptr, rr_ptr+1, … and wraps modulo CHANNELS.
- Grant rule: if en=1 and any req_valid bit is set, exactly one req_ready bit is asserted: the first valid channel in search order. All other req_ready bits are 0. If en=0, or no request is valid, req_ready is all 0.
- req_ready never asserts for a channel whose req_valid is 0.
- When a grant is issued on a clock edge:
  - rr_ptr becomes (granted index + 1) mod CHANNELS.
  - wr_addr, wr_chan and wr_valid=1 are registered.
  - wr_en is set to the one-hot decode of the granted address.
- When no grant is issued, wr_en becomes all 0, wr_valid becomes 0, and wr_addr and wr_chan hold their values.
- Requesters must hold valid and addr stable until accepted. The block does not buffer requests.
- Two channels requesting the same address in the same cycle are treated as ordinary contention: one is granted, the other waits. No merging.
- stall_cnt adds the number of channels with valid=1 and ready=0 each cycle (0..CHANNELS). It saturates at 2^CNT_W-1 and never wraps.
- Invariant: wr_en is always zero or exactly one-hot, and wr_valid equals the OR of wr_en.

## Timing
- Latency: a request accepted at edge N appears on wr_en, wr_valid, wr_addr and wr_chan immediately after edge N. It is visible for the whole cycle N→N+1 and is gone after edge N+1 unless a new grant occurs.
- req_ready is purely combinational from req_valid, en and rr_ptr. It has no combinational path from req_addr.
- Throughput: one write per cycle. A sustained single requester is granted every cycle.
- Reset: while reset=0, all of the following hold asynchronously: wr_en=0, wr_valid=0, wr_addr=0, wr_chan=0, rr_ptr=0, stall_cnt=0. req_ready is 0 while reset is asserted.
- Reset mid-operation: any pending write is dropped, not replayed. After release, arbitration restarts from channel 0.
- Deassertion of en takes effect in the same cycle: no grant. wr_valid falls after the next edge.

## Configuration
- ZERO_REG_SUPPRESS_EN defined:
  - A granted request to address 2^ADDR_W-1 (the zero register) is still consumed and still advances rr_ptr.
  - It registers wr_en=0 and wr_valid=0; wr_addr and wr_chan still update.
  - It does not count as a stall.
- ZERO_REG_SUPPRESS_EN undefined: address 2^ADDR_W-1 decodes like any other address (wr_en bit 2^ADDR_W-1 set, wr_valid=1).

## Test plan
- Reset and decode sweep: reset=0 → all outputs 0. Release; drive channel 0 only, addr 0..30 on consecutive cycles → req_ready[0]=1 every cycle; wr_en=1<<addr one cycle later; wr_chan=0; stall_cnt stays 0.
- Contention: CHANNELS=2, both valid, addr 3 on channel 0 and addr 7 on channel 1, held four cycles → grants alternate 0,1,0,1; wr_en=0x8, 0x80, 0x8, 0x80; stall_cnt=4.
- Global enable: en=0 with both channels valid for three cycles → req_ready=0; wr_valid=0; stall_cnt increases by 6.
- Zero register: channel 0 addr 31 → with ZERO_REG_SUPPRESS_EN, ready=1 and next cycle wr_en=0, wr_valid=0, wr_addr=31; without it, wr_en=0x80000000 and wr_valid=1.
- Mid-operation reset: reset=0 during a cycle with wr_valid=1 → outputs clear immediately. After release, with both channels valid, channel 0 is granted first.
- Saturation: CNT_W=4, three channels stalled for ten cycles → stall_cnt=15 and holds at 15.
